// File: rtl/tl_buffer_ad_if.sv
// tl_buffer_ad_if: one TileLink link carrying an A channel (master to slave) and a D channel (slave to master).
interface tl_buffer_ad_if;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_bits_opcode;
    logic [2:0]  a_bits_param;
    logic [3:0]  a_bits_size;
    logic [4:0]  a_bits_source;
    logic [27:0] a_bits_address;
    logic [3:0]  a_bits_mask;
    logic [31:0] a_bits_data;
    logic        a_bits_corrupt;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic [4:0]  d_bits_source;
    logic        d_bits_sink;
    logic        d_bits_denied;
    logic [31:0] d_bits_data;
    logic        d_bits_corrupt;

    modport master (
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready
    );

    modport slave (
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready
    );
endinterface

// File: rtl/tl_buffer_ad.sv
// tl_buffer_ad: independent registered FIFOs on the TileLink A (in->out) and D (out->in) channels.
module tl_buffer_ad_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enq_valid,
    output logic         enq_ready,
    input  logic [W-1:0] enq_bits,
    output logic         deq_valid,
    input  logic         deq_ready,
    output logic [W-1:0] deq_bits
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] count;
    logic          do_enq, do_deq;

    // Ready and valid come from the registered count only: no flow-through, no pass-through
    assign enq_ready = count != FULL;
    assign deq_valid = count != '0;
    assign deq_bits  = mem[rd];
    assign do_enq    = enq_valid && enq_ready;
    assign do_deq    = deq_valid && deq_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_enq) begin
                mem[wr] <= enq_bits;
                wr      <= (wr == LAST) ? '0 : wr + 1'b1;
            end
            if (do_deq) rd <= (rd == LAST) ? '0 : rd + 1'b1;
            if (do_enq != do_deq) count <= do_enq ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule

module tl_buffer_ad #(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    tl_buffer_ad_if.slave  auto_in,
    tl_buffer_ad_if.master auto_out
);
    localparam int AW = 80;
    localparam int DW = 49;

    logic [AW-1:0] a_enq, a_deq;
    logic [DW-1:0] d_enq, d_deq;

    assign a_enq = {auto_in.a_bits_opcode, auto_in.a_bits_param, auto_in.a_bits_size,
                    auto_in.a_bits_source, auto_in.a_bits_address, auto_in.a_bits_mask,
                    auto_in.a_bits_data, auto_in.a_bits_corrupt};
    assign {auto_out.a_bits_opcode, auto_out.a_bits_param, auto_out.a_bits_size,
            auto_out.a_bits_source, auto_out.a_bits_address, auto_out.a_bits_mask,
            auto_out.a_bits_data, auto_out.a_bits_corrupt} = a_deq;

    assign d_enq = {auto_out.d_bits_opcode, auto_out.d_bits_param, auto_out.d_bits_size,
                    auto_out.d_bits_source, auto_out.d_bits_sink, auto_out.d_bits_denied,
                    auto_out.d_bits_data, auto_out.d_bits_corrupt};
    assign {auto_in.d_bits_opcode, auto_in.d_bits_param, auto_in.d_bits_size,
            auto_in.d_bits_source, auto_in.d_bits_sink, auto_in.d_bits_denied,
            auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_deq;

    tl_buffer_ad_queue #(.W(AW), .DEPTH(A_DEPTH)) a_q (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in.a_valid),
        .enq_ready (auto_in.a_ready),
        .enq_bits  (a_enq),
        .deq_valid (auto_out.a_valid),
        .deq_ready (auto_out.a_ready),
        .deq_bits  (a_deq)
    );

    tl_buffer_ad_queue #(.W(DW), .DEPTH(D_DEPTH)) d_q (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out.d_valid),
        .enq_ready (auto_out.d_ready),
        .enq_bits  (d_enq),
        .deq_valid (auto_in.d_valid),
        .deq_ready (auto_in.d_ready),
        .deq_bits  (d_deq)
    );
endmodule
